// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through receive FIFO.
// Sticky overrun / framing flags and a registered interrupt output.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   rx         asynchronous serial input, idle high, LSB first
//   rd_en      pop strobe, one entry per cycle when not empty
//   clr_err    clears overrun and frame_err (a same-cycle set wins)
//   data_out   FIFO head byte, 0x00 when empty
//   empty      FIFO holds no entries
//   full       FIFO holds FIFO_DEPTH entries
//   count      current FIFO occupancy
//   overrun    sticky: a byte was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
//   irq        registered (!empty | overrun | frame_err)
module uart_rx_fifo #(
    parameter int CLK_DIV    = 217,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx,
    input  logic                         rd_en,
    input  logic                         clr_err,
    output logic [7:0]                   data_out,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         overrun,
    output logic                         frame_err,
    output logic                         irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [15:0] HALF_CNT = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] BIT_CNT  = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // The synchronizer resets to 1, so its first two outputs after
    // reset are not real line samples. Arming waits until rxs
    // actually reflects rx, otherwise a line held low through reset
    // would look like idle-high followed by a start edge.
    logic [1:0] r_warm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm <= 2'd0;
        end else if (r_warm != 2'd2) begin
            r_warm <= r_warm + 2'd1;
        end
    end

    // ------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------
    state_t      r_state;
    state_t      w_next;
    logic        r_armed;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic [7:0]  r_shift;
    logic        w_sample;
    logic        w_push;
    logic        w_ferr;
    logic        w_disarm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt + 16'd1;
        w_idx_next = r_idx;
        w_sample   = 1'b0;
        w_push     = 1'b0;
        w_ferr     = 1'b0;
        w_disarm   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_next = 16'd0;
                w_idx_next = 3'd0;
                if (r_armed && !w_rxs) begin
                    w_next   = S_START;
                    w_disarm = 1'b1;
                end
            end
            S_START: begin
                if (r_cnt == HALF_CNT) begin
                    w_cnt_next = 16'd0;
                    w_idx_next = 3'd0;
                    // High at mid start bit is a glitch.
                    w_next = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_CNT) begin
                    w_cnt_next = 16'd0;
                    w_sample   = 1'b1;
                    w_idx_next = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_CNT) begin
                    w_cnt_next = 16'd0;
                    w_next     = S_IDLE;
                    if (w_rxs) begin
                        w_push = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
        endcase
    end

    // Arms only from a high line sample while idle; cleared when a
    // start is taken so a frame must end with rxs high to re-arm.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (w_disarm) begin
            r_armed <= 1'b0;
        end else if (r_state == S_IDLE && r_warm == 2'd2 && w_rxs) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= 8'h00;
        end else if (w_sample) begin
            r_shift[r_idx] <= w_rxs;
        end
    end

    // ------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_wr;
    logic          w_ovr_set;

    assign empty = (r_count == '0);
    assign full  = (r_count == DEPTH_C);
    assign count = r_count;

    // A pop in the same cycle frees the slot, so a full FIFO still
    // accepts the incoming byte.
    assign w_pop     = rd_en && !empty;
    assign w_wr      = w_push && (!full || w_pop);
    assign w_ovr_set = w_push && full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_out = empty ? 8'h00 : r_mem[r_rptr];

    // ------------------------------------------------------------
    // Sticky flags and interrupt
    // ------------------------------------------------------------
    logic r_overrun;
    logic r_frame_err;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_ferr) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            r_irq <= !empty || r_overrun || r_frame_err;
        end
    end

    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign irq       = r_irq;

endmodule
